// File: rtl/matrix_operand_loader.sv
// Streams 18 elements into a dividend/divisor 3x3 matrix pair and holds them for matrix_division.
// Optional divisor zero detection is enabled by defining MATRIX_ZERO_CHECK_EN.
module matrix_operand_loader #(
    parameter int unsigned DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    output logic [9*DATA_W-1:0] mat0_flat,
    output logic [9*DATA_W-1:0] mat1_flat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                div_zero
);

    localparam int unsigned N_ELEM = 9;
    localparam int unsigned N_BEAT = 2 * N_ELEM;
    localparam int unsigned CNT_W  = 5;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEAT - 1);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [N_BEAT-1:0][DATA_W-1:0]  elem_q, elem_d;
    logic                           in_ready_q, in_ready_d;
    logic                           out_valid_q, out_valid_d;

    // Next-state, beat counter and element write path.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        elem_d      = elem_q;
        case (state_q)
            ST_LOAD: begin
                if (flush) begin
                    cnt_d = '0;
                end else if (in_valid) begin
                    for (int k = 0; k < int'(N_BEAT); k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            elem_d[k] = in_data;
                        end
                    end
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_FULL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase
        in_ready_d  = (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            elem_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            elem_q      <= elem_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign mat0_flat = elem_q[N_ELEM-1:0];
    assign mat1_flat = elem_q[N_BEAT-1:N_ELEM];

`ifdef MATRIX_ZERO_CHECK_EN
    logic div_zero_q, div_zero_d;

    // Flag is evaluated on the elements that will be held in FULL, so it rises with out_valid.
    always_comb begin
        div_zero_d = 1'b0;
        if (state_d == ST_FULL) begin
            for (int k = 0; k < int'(N_ELEM); k++) begin
                if (elem_d[N_ELEM + k] == '0) begin
                    div_zero_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_zero_q <= 1'b0;
        end else begin
            div_zero_q <= div_zero_d;
        end
    end

    assign div_zero = div_zero_q;
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed self-checking bench for matrix_operand_loader (DATA_W=16).
module tb_matrix_operand_loader;

    localparam int unsigned W  = 16;
    localparam int unsigned FW = 9 * W;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic [FW-1:0] mat0_flat;
    logic [FW-1:0] mat1_flat;
    logic          out_valid;
    logic          out_ready;
    logic          div_zero;

    int checks;
    int failures;

    logic [W-1:0] v0 [9];
    logic [W-1:0] v1 [9];

`ifdef MATRIX_ZERO_CHECK_EN
    localparam logic ZERO_EXP = 1'b1;
`else
    localparam logic ZERO_EXP = 1'b0;
`endif

    matrix_operand_loader #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mat0_flat (mat0_flat),
        .mat1_flat (mat1_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FW-1:0] pack0();
        logic [FW-1:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[W*k +: W] = v0[k];
        return r;
    endfunction

    function automatic logic [FW-1:0] pack1();
        logic [FW-1:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[W*k +: W] = v1[k];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_pair();
        for (int k = 0; k < 9; k++) beat(v0[k]);
        for (int k = 0; k < 9; k++) beat(v1[k]);
    endtask

    task automatic release_pair();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || mat0_flat !== '0 || mat1_flat !== '0 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: ov=%b m0=%h m1=%h dz=%b, want 0/0/0/0", out_valid, mat0_flat, mat1_flat, div_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_load();
        logic [W-1:0] a0 [9] = '{16'd128, 16'd16, 16'd128, 16'd8, 16'd2, 16'd1, 16'd2, 16'd16, 16'd2};
        logic [W-1:0] a1 [9] = '{16'd4, 16'd2, 16'd1, 16'd1, 16'd1, 16'd32, 16'd4, 16'd512, 16'd2};
        v0 = a0;
        v1 = a1;
        for (int k = 0; k < 9; k++) beat(v0[k]);
        for (int k = 0; k < 8; k++) beat(v1[k]);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_before_last: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
        beat(v1[8]);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL load_full: ov=%b ir=%b dz=%b, want 1/0/0", out_valid, in_ready, div_zero);
        end
        checks++;
        if (mat0_flat !== pack0() || mat1_flat !== pack1()) begin
            failures++;
            $display("FAIL load_flats: m0=%h m1=%h, want %h %h", mat0_flat, mat1_flat, pack0(), pack1());
        end
    endtask

    task automatic test_full_hold();
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        flush    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || mat0_flat !== pack0() || mat1_flat !== pack1()) begin
                failures++;
                $display("FAIL full_hold c%0d: ov=%b ir=%b m0=%h m1=%h, want 1/0 %h %h",
                         c, out_valid, in_ready, mat0_flat, mat1_flat, pack0(), pack1());
            end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        release_pair();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL full_release: ov=%b ir=%b dz=%b, want 0/1/0", out_valid, in_ready, div_zero);
        end
        checks++;
        if (mat0_flat !== pack0()) begin
            failures++;
            $display("FAIL full_release_keep: m0=%h, want %h", mat0_flat, pack0());
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] old7;
        old7 = v0[7];
        for (int k = 0; k < 7; k++) begin
            v0[k] = W'(100 + k);
            beat(v0[k]);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h7777;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (mat0_flat !== pack0() || mat0_flat[W*7 +: W] !== old7 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_discard: m0=%h ov=%b, want %h 0", mat0_flat, out_valid, pack0());
        end
        for (int k = 0; k < 9; k++) v0[k] = W'(200 + k);
        for (int k = 0; k < 9; k++) v1[k] = W'(220 + k);
        // The first post-flush beat must land in element a of mat0.
        beat(v0[0]);
        checks++;
        if (mat0_flat[W-1:0] !== v0[0]) begin
            failures++;
            $display("FAIL flush_restart: elem_a=%h, want %h", mat0_flat[W-1:0], v0[0]);
        end
        for (int k = 1; k < 9; k++) beat(v0[k]);
        for (int k = 0; k < 9; k++) beat(v1[k]);
        checks++;
        if (out_valid !== 1'b1 || mat0_flat !== pack0() || mat1_flat !== pack1()) begin
            failures++;
            $display("FAIL flush_reload: ov=%b m0=%h m1=%h, want 1 %h %h", out_valid, mat0_flat, mat1_flat, pack0(), pack1());
        end
        release_pair();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 12; k++) beat(W'(16'h0A00 + k));
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || mat0_flat !== '0 || mat1_flat !== '0) begin
            failures++;
            $display("FAIL async_reset: ov=%b m0=%h m1=%h, want 0/0/0", out_valid, mat0_flat, mat1_flat);
        end
        #2;
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 9; k++) v0[k] = W'(300 + k);
        for (int k = 0; k < 9; k++) v1[k] = W'(330 + k);
        load_pair();
        checks++;
        if (out_valid !== 1'b1 || mat0_flat !== pack0() || mat1_flat !== pack1()) begin
            failures++;
            $display("FAIL async_reset_reload: ov=%b m0=%h m1=%h, want 1 %h %h", out_valid, mat0_flat, mat1_flat, pack0(), pack1());
        end
        release_pair();
    endtask

    task automatic test_zero();
        for (int k = 0; k < 9; k++) v0[k] = W'(16'h0050 + k);
        for (int k = 0; k < 9; k++) v1[k] = W'(16'h0060 + k);
        v1[4] = '0;
        load_pair();
        checks++;
        if (out_valid !== 1'b1 || div_zero !== ZERO_EXP) begin
            failures++;
            $display("FAIL zero_flag: ov=%b dz=%b, want 1 %b", out_valid, div_zero, ZERO_EXP);
        end
        release_pair();
        checks++;
        if (div_zero !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_clear: dz=%b ov=%b, want 0/0", div_zero, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int j;
        int rises;
        logic prev_ov;
        j       = 0;
        rises   = 0;
        prev_ov = out_valid;
        for (int k = 0; k < 9; k++) v0[k] = W'(16'h1000 + k);
        for (int k = 0; k < 9; k++) v1[k] = W'(16'h2000 + k);
        for (int c = 0; c < 36; c++) begin
            if (c % 2 == 0) begin
                in_valid = 1'b1;
                in_data  = (j < 9) ? v0[j] : v1[j - 9];
                j++;
            end else begin
                in_valid = 1'b0;
                in_data  = 16'hDEAD;
            end
            tick();
            if (out_valid === 1'b1 && prev_ov !== 1'b1) rises++;
            prev_ov = out_valid;
        end
        in_valid = 1'b0;
        checks++;
        if (rises !== 1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL toggle_once: rises=%0d ov=%b, want 1 1", rises, out_valid);
        end
        checks++;
        if (mat0_flat !== pack0() || mat1_flat !== pack1()) begin
            failures++;
            $display("FAIL toggle_order: m0=%h m1=%h, want %h %h", mat0_flat, mat1_flat, pack0(), pack1());
        end
        release_pair();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_load();
        test_full_hold();
        test_flush();
        test_async_reset();
        test_zero();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_operand_loader.md
MATRIX_OPERAND_LOADER -- requirements
Module: matrix_operand_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, element width in bits (matrix_division operand width).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  synchronous abort of a partial load.
REQ-005 SHALL have port in_valid  input  1  upstream element valid.
REQ-006 SHALL have port in_data  input  DATA_W  upstream element, two's-complement.
REQ-007 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-008 SHALL have port mat0_flat  output  9*DATA_W  dividend matrix, element k at bits [16k+15:16k], k=0..8 = a..i, bit 0 = LSB (a00).
REQ-009 SHALL have port mat1_flat  output  9*DATA_W  divisor matrix, same packing (a10..i115).
REQ-010 SHALL have port out_valid  output  1  both matrices complete and stable for matrix_division.
REQ-011 SHALL have port out_ready  input  1  downstream has sampled matrix_division results.
REQ-012 SHALL have port div_zero  output  1  divisor contains a zero element (see Configuration).

Function
REQ-013 SHALL accept an element only on a beat: in_valid=1 and in_ready=1 at a rising edge.
REQ-014 SHALL load beats in fixed order: beats 0-8 fill mat0 elements a..i row-major, beats 9-17 fill mat1 elements a..i.
REQ-015 SHALL use a 5-bit beat counter, 0..17, incremented per beat, never wrapping past 17.
REQ-016 SHALL implement two states: LOAD (in_ready=1, out_valid=0) and FULL (in_ready=0, out_valid=1).
REQ-017 SHALL transition LOAD->FULL on the beat with counter=17; out_valid rises the cycle after the 18th beat (latency 1).
REQ-018 SHALL transition FULL->LOAD when out_valid=1 and out_ready=1 at a rising edge, clearing the counter to 0.
REQ-019 SHALL hold mat0_flat/mat1_flat unchanged throughout FULL; in LOAD only the addressed element register changes per beat.
REQ-020 SHALL, on flush=1 in LOAD, clear the counter to 0 next cycle, discard that cycle's beat, and keep stored element values.
REQ-021 SHALL ignore flush in FULL (the completed pair is not discarded).
REQ-022 SHALL give flush priority over a simultaneous in_valid beat.
REQ-023 SHALL ignore in_data when in_valid=0; out_ready while in LOAD has no effect.

Reset
REQ-024 SHALL, on rst_n=0, immediately and asynchronously force state=LOAD, counter=0, all element registers=0, out_valid=0, div_zero=0; in_ready=1 once rst_n=1.
REQ-025 SHALL, on reset mid-load or in FULL, discard all partial/complete data; next beat after release is beat 0.

Configuration
REQ-026 SHALL support macro MATRIX_ZERO_CHECK_EN.
REQ-027 With MATRIX_ZERO_CHECK_EN defined: div_zero SHALL be registered, valid exactly while out_valid=1, =1 iff any mat1 element equals 0, cleared on leaving FULL.
REQ-028 Without MATRIX_ZERO_CHECK_EN: div_zero SHALL be tied 0 and no comparator logic SHALL be generated.

Verification
REQ-029 Reset, then 18 beats back-to-back: mat0 = 128,16,128,8,2,1,2,16,2; mat1 = 4,2,1,1,1,32,4,512,2 -> out_valid=1 cycle after beat 18, flats match packing, in_ready=0, div_zero=0.
REQ-030 In FULL, drive in_valid=1 in_data=0xFFFF for 5 cycles with out_ready=0 -> flats unchanged, out_valid held; then out_ready=1 one cycle -> LOAD, counter 0, in_ready=1.
REQ-031 Load 7 beats, assert flush together with beat 8 -> beat discarded; next 18 beats form a complete new pair, out_valid after 18th.
REQ-032 Drop rst_n asynchronously (between edges) after 12 beats -> out_valid=0, flats=0 immediately; 18 fresh beats after release complete normally.
REQ-033 With MATRIX_ZERO_CHECK_EN, mat1 element e = 0 -> div_zero=1 with out_valid; without macro same stimulus -> div_zero=0.
REQ-034 in_valid toggling 1/0 each cycle for 36 cycles -> exactly 18 beats accepted, out_valid once, order preserved.
